// File: rtl/popcount_window.sv
// popcount_window: registered popcount of each accepted sample, totalled over
// a tumbling or sliding window of WINDOW samples.
module popcount_window #(
  parameter int WIDTH = 3,
  parameter int WINDOW = 4,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int SW = $clog2(WIDTH * WINDOW + 1),
  localparam int FW = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [CW-1:0]    cnt,
  output logic             cnt_valid,
  output logic [SW-1:0]    sum,
  output logic             out_valid,
  output logic [FW-1:0]    fill,
  output logic             mode_q
);
  localparam int PW = $clog2(WINDOW);
  logic [CW-1:0] pc;
  logic [CW-1:0] hist [WINDOW];
  logic [PW-1:0] wp;
  logic [SW-1:0] acc, oldest, sum_nx;
  logic full, last;
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + CW'(in_data[i]);
  end
  assign full = fill == FW'(WINDOW);
  assign last = fill == FW'(WINDOW - 1);
  // the slot under the write pointer is the oldest entry once history is full
  assign oldest = full ? SW'(hist[wp]) : '0;
  assign sum_nx = mode_q ? sum + SW'(pc) - oldest : acc + SW'(pc);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      cnt_valid <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
      fill      <= '0;
      mode_q    <= 1'b0;
      acc       <= '0;
      wp        <= '0;
      for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
    end else if (clr) begin
      cnt       <= '0;
      cnt_valid <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
      fill      <= '0;
      mode_q    <= mode;
      acc       <= '0;
      wp        <= '0;
      for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
    end else begin
      cnt_valid <= in_valid;
      out_valid <= in_valid && (last || (mode_q && full));
      if (in_valid) begin
        cnt <= pc;
        if (mode_q) begin
          sum      <= sum_nx;
          hist[wp] <= pc;
          wp       <= wp == PW'(WINDOW - 1) ? '0 : wp + PW'(1);
          fill     <= full ? fill : fill + FW'(1);
        end else if (last) begin
          sum  <= sum_nx;
          acc  <= '0;
          fill <= '0;
        end else begin
          acc  <= sum_nx;
          fill <= fill + FW'(1);
        end
      end
    end
endmodule

// File: tb/tb_popcount_window.sv
// tb_popcount_window: directed vectors against a 3x4 and an 8x16 instance.
module tb_popcount_window;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clr = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic [1:0] cnt;
  logic cnt_valid, out_valid, mode_q;
  logic [3:0] sum;
  logic [2:0] fill;
  logic b_clr = 1'b0, b_mode = 1'b0, b_valid = 1'b0;
  logic [7:0] b_data = '0;
  logic [3:0] b_cnt;
  logic b_cnt_valid, b_out_valid, b_mode_q;
  logic [7:0] b_sum;
  logic [4:0] b_fill;
  int n_chk = 0, n_pass = 0;
  popcount_window dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .cnt(cnt), .cnt_valid(cnt_valid), .sum(sum),
    .out_valid(out_valid), .fill(fill), .mode_q(mode_q)
  );
  popcount_window #(.WIDTH(8), .WINDOW(16)) big (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .mode(b_mode), .in_valid(b_valid),
    .in_data(b_data), .cnt(b_cnt), .cnt_valid(b_cnt_valid), .sum(b_sum),
    .out_valid(b_out_valid), .fill(b_fill), .mode_q(b_mode_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic smp(input logic v, input logic [2:0] d);
    in_valid = v;
    in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic do_clr(input logic m);
    clr = 1'b1;
    mode = m;
    smp(1'b0, 3'd0);
    clr = 1'b0;
  endtask
  task automatic bsmp(input logic [7:0] d);
    b_valid = 1'b1;
    b_data = d;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask
  initial begin
    int cnt_e [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
    int tsum_e [8] = '{0, 0, 0, 4, 4, 4, 4, 8};
    int tfill_e [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int ssum_e [8] = '{0, 1, 2, 4, 5, 6, 7, 8};
    int sfill_e [8] = '{1, 2, 3, 4, 4, 4, 4, 4};
    #2;
    chk("rst_sum", sum, 0);
    chk("rst_fill", fill, 0);
    chk("rst_mode", mode_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // tumbling, continuous
    for (int i = 0; i < 8; i++) begin
      smp(1'b1, 3'(i));
      chk($sformatf("t_cnt%0d", i), cnt, cnt_e[i]);
      chk($sformatf("t_cv%0d", i), cnt_valid, 1);
      chk($sformatf("t_sum%0d", i), sum, tsum_e[i]);
      chk($sformatf("t_fill%0d", i), fill, tfill_e[i]);
      chk($sformatf("t_ov%0d", i), out_valid, int'(i == 3 || i == 7));
    end
    // sliding
    do_clr(1'b1);
    chk("s_clr_mode", mode_q, 1);
    chk("s_clr_sum", sum, 0);
    chk("s_clr_cnt", cnt, 0);
    for (int i = 0; i < 8; i++) begin
      smp(1'b1, 3'(i));
      chk($sformatf("s_sum%0d", i), sum, ssum_e[i]);
      chk($sformatf("s_fill%0d", i), fill, sfill_e[i]);
      chk($sformatf("s_ov%0d", i), out_valid, int'(i >= 3));
    end
    // mode change without clr: still sliding, oldest is sample 100 (pc 1)
    mode = 1'b0;
    smp(1'b1, 3'b111);
    chk("nomode_mq", mode_q, 1);
    chk("nomode_sum", sum, 10);
    chk("nomode_ov", out_valid, 1);
    // gaps and clr collision
    do_clr(1'b0);
    chk("g_mode", mode_q, 0);
    smp(1'b1, 3'b111);
    chk("g_fill1", fill, 1);
    for (int i = 0; i < 2; i++) begin
      smp(1'b0, 3'b111);
      chk($sformatf("g_cv%0d", i), cnt_valid, 0);
      chk($sformatf("g_ov%0d", i), out_valid, 0);
      chk($sformatf("g_cnt%0d", i), cnt, 3);
      chk($sformatf("g_fill%0d", i), fill, 1);
    end
    smp(1'b1, 3'b111);
    chk("g_fill2", fill, 2);
    chk("g_sum", sum, 0);
    clr = 1'b1;
    smp(1'b1, 3'b111);
    clr = 1'b0;
    chk("c_sum", sum, 0);
    chk("c_fill", fill, 0);
    chk("c_cnt", cnt, 0);
    chk("c_cv", cnt_valid, 0);
    // reset mid-window
    do_clr(1'b1);
    for (int i = 0; i < 3; i++) smp(1'b1, 3'b111);
    chk("r_sum9", sum, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_sum", sum, 0);
    chk("r_cnt", cnt, 0);
    chk("r_fill", fill, 0);
    chk("r_mode", mode_q, 0);
    chk("r_cv", cnt_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("r_hold", sum, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp(1'b1, 3'b001);
      chk($sformatf("r_ov%0d", i), out_valid, int'(i == 3));
      chk($sformatf("r_sum%0d", i), sum, i == 3 ? 4 : 0);
    end
    // wide instance, sliding wrap
    b_clr = 1'b1;
    b_mode = 1'b1;
    @(posedge clk);
    #1;
    b_clr = 1'b0;
    chk("b_mode", b_mode_q, 1);
    for (int i = 0; i < 16; i++) begin
      bsmp(8'hff);
      chk($sformatf("b_up%0d", i), b_sum, 8 * (i + 1));
      chk($sformatf("b_upov%0d", i), b_out_valid, int'(i == 15));
    end
    chk("b_cnt", b_cnt, 8);
    chk("b_fill", b_fill, 16);
    for (int i = 0; i < 16; i++) begin
      bsmp(8'h00);
      chk($sformatf("b_dn%0d", i), b_sum, 128 - 8 * (i + 1));
      chk($sformatf("b_dnov%0d", i), b_out_valid, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/popcount_window.md
# popcount_window

Parametrised successor to the team's 3-input ones counter. It registers the popcount of a WIDTH-bit input sample and accumulates those counts over a window of WINDOW accepted samples. The window runs in tumbling mode (one total per block of samples) or sliding mode (running total of the last WINDOW samples). It sits between a sample source with a valid strobe and downstream threshold/statistics logic.

## Interface
- WIDTH, 3: bits per input sample; WIDTH ≥ 1.
- WINDOW, 4: samples per window; WINDOW ≥ 2.
- Derived, not overridable:
  - CW = clog2(WIDTH+1)
  - SW = clog2(WIDTH*WINDOW+1)
  - FW = clog2(WINDOW+1)
- clk  in  1  rising-edge clock; the block's single clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; also latches `mode`.
- mode  in  1  0 = tumbling, 1 = sliding; sampled only on a `clr` cycle.
- in_valid  in  1  sample strobe; the sample is accepted on any edge with in_valid=1 and clr=0.
- in_data  in  WIDTH  sample bits.
- cnt  out  CW  popcount of the last accepted sample.
- cnt_valid  out  1  one-cycle pulse: `cnt` updated.
- sum  out  SW  window total (see Operation).
- out_valid  out  1  one-cycle pulse: `sum` holds a new valid total.
- fill  out  FW  accepted samples in the current window (tumbling) or the history depth (sliding).
- mode_q  out  1  active mode.

## Operation
- **Reset (rst_n=0, immediate):** cnt, cnt_valid, sum, out_valid, fill, mode_q, accumulator, history and pointers all go to 0. Active mode is tumbling.
- **clr=1 (edge):** same effect as reset, except mode_q ← mode. clr beats in_valid: a sample in the clr cycle is dropped.
- **Accepted sample:**
  - cnt ← popcount(in_data) and cnt_valid=1.
  - With no accepted sample, cnt holds and cnt_valid=0.
- **Tumbling (mode_q=0):**
  - Internal acc ← acc + pc, fill ← fill + 1.
  - On the WINDOW-th sample: sum ← acc + pc, out_valid=1, acc ← 0, fill ← 0.
  - sum holds until the next window completes.
- **Sliding (mode_q=1):**
  - Circular history of WINDOW entries, CW bits each.
  - Per accepted sample: sum ← sum + pc − oldest, where oldest = 0 while fill < WINDOW. The new pc overwrites the oldest slot and the write pointer wraps WINDOW−1 → 0.
  - fill saturates at WINDOW.
  - out_valid=1 on every accepted sample that leaves fill = WINDOW.
  - While filling, sum is the partial total and out_valid=0.
- **Arithmetic:** all unsigned. Widths cover the maximum WIDTH*WINDOW, so no overflow or saturation logic is needed.
- **No clock gaps:** in_valid=0 cycles freeze all state; pulses drop to 0.

## Timing
- **Latency:** 1 cycle from the accepting edge to cnt/cnt_valid/sum/out_valid/fill.
- **Throughput:** one sample per clock, sustained, in either mode.
- **Pulses:** cnt_valid and out_valid are high for exactly one cycle per qualifying accepted sample. Back-to-back samples give back-to-back pulses.
- **clr timing:** clr takes effect at the edge. All outputs read 0 in the following cycle, except mode_q.
- **mode changes:** a mode change without clr is ignored.
- **Reset mid-window:** rst_n asserted mid-window discards the partial window; no out_valid is produced for it.

## Test plan
1. **Defaults, tumbling, continuous:** in_data 000,001,…,111 with in_valid=1 continuously.
   - cnt = 0,1,1,2,1,2,2,3.
   - out_valid after samples 4 and 8 with sum = 4 then 8.
   - fill sequence 1,2,3,0,1,2,3,0.
2. **Defaults, sliding:** clr with mode=1, then the same 8 samples.
   - out_valid on samples 4–8 with sum = 4,5,6,7,8.
   - sum before that = 0,1,2; fill stays 4 after sample 4.
3. **Gaps and collisions:** tumbling, samples 111,111 with in_valid=0 gaps between them.
   - State holds across gaps; no spurious pulses.
   - clr with in_valid=1 and data 111: sample dropped, sum=0, fill=0, cnt=0.
4. **Reset mid-window:** sliding, 3 samples of 111 (sum=9), then rst_n low for 2 cycles.
   - All outputs go to 0 asynchronously and mode_q=0.
   - Next 4 samples of 001 in tumbling give one out_valid with sum=4.
5. **Width/wrap stress:** WIDTH=8, WINDOW=16, sliding.
   - 16 × 0xFF gives sum=128 (SW=8, no overflow).
   - 16 × 0x00 then ramps sum down by 8 per sample to 0, exercising pointer wrap.
6. **Mode without clr:** toggle mode without clr → mode_q and behaviour unchanged.
